// File: rtl/spi_byte_shifter.sv
// SPI mode-0 master shifter: sends an N-bit word MSB first and optionally captures miso.
// Define SPI_BYTE_SHIFTER_RX_EN to build the receive path; otherwise o_rx_data is tied to 0.
module spi_byte_shifter #(
    parameter int unsigned N   = 8,
    parameter int unsigned DIV = 4
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_start,
    input  logic [N-1:0] i_tx_data,
    input  logic         i_miso,
    output logic         o_sclk,
    output logic         o_mosi,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_rx_data
);

    localparam int unsigned HcW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BcW = $clog2(2 * N);
    localparam logic [HcW-1:0] HcLast = HcW'(DIV - 1);
    localparam logic [BcW-1:0] BcLast = BcW'(2 * N - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e         r_state;
    logic [HcW-1:0] r_hc;
    logic [BcW-1:0] r_bc;
    logic [N-1:0]   r_shift;
    logic           r_sclk;
    logic           r_busy;
    logic           r_done;

    logic w_half_end;
    logic w_last_half;

    assign w_half_end  = (r_hc == HcLast);
    assign w_last_half = (r_bc == BcLast);

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_state <= StIdle;
            r_hc    <= '0;
            r_bc    <= '0;
            r_shift <= '0;
            r_sclk  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_shift <= i_tx_data;
                        r_hc    <= '0;
                        r_bc    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    if (w_half_end) begin
                        r_hc   <= '0;
                        r_sclk <= ~r_sclk;
                        if (w_last_half) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_bc <= r_bc + BcW'(1);
                            // Falling sclk edge: advance to the next bit (never after the last one).
                            if (r_sclk) begin
                                r_shift <= {r_shift[N-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_hc <= r_hc + HcW'(1);
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_sclk = r_sclk;
    assign o_mosi = (r_state == StShift) ? r_shift[N-1] : 1'b1;
    assign o_busy = r_busy;
    assign o_done = r_done;

`ifdef SPI_BYTE_SHIFTER_RX_EN
    logic [N-1:0] r_rx_shift;
    logic [N-1:0] r_rx_data;

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_rx_shift <= '0;
            r_rx_data  <= '0;
        end else begin
            // Rising sclk edge: capture miso.
            if (r_state == StShift && w_half_end && !r_sclk) begin
                r_rx_shift <= {r_rx_shift[N-2:0], i_miso};
            end
            if (r_state == StDone) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    assign o_rx_data = r_rx_data;
`else
    logic w_unused_miso;

    assign w_unused_miso = i_miso;
    assign o_rx_data     = '0;
`endif

endmodule
